// File: rtl/sine_mux_ctrl_pkg.sv
// Shared constants and types for the time-multiplexed sine channel controller.
// The pending-config struct is sized for the largest supported build (16 channels, 32-bit phase).
package sine_mux_ctrl_pkg;

    localparam int DEF_NCH         = 4;
    localparam int DEF_SINEROMSIZE = 256;
    localparam int DEF_PHASEW      = 24;

    localparam int CFG_CH_MAXW   = 4;
    localparam int CFG_STEP_MAXW = 32;

    typedef struct packed {
        logic [CFG_CH_MAXW-1:0]   ch;
        logic [CFG_STEP_MAXW-1:0] step;
        logic                     phase_clr;
    } pend_cfg_t;

endpackage

// File: rtl/sine_mux_ctrl_phase_acc.sv
// Per-channel phase accumulators with step registers; one channel advances per issue slot.
// A load replaces the step of one channel and may zero its phase, overriding that edge's advance.
module sine_phase_acc
    import sine_mux_ctrl_pkg::*;
#(
    parameter  int NCH    = DEF_NCH,
    parameter  int PHASEW = DEF_PHASEW,
    localparam int CW     = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic [CW-1:0]     i_sel,
    input  logic              i_load,
    input  logic [CW-1:0]     i_load_ch,
    input  logic [PHASEW-1:0] i_load_step,
    input  logic              i_load_clr,
    output logic [PHASEW-1:0] o_phase
);

    logic [PHASEW-1:0] r_step  [NCH];
    logic [PHASEW-1:0] r_phase [NCH];

    // step/phase registers: the advancing slot always uses the step held before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_step[c]  <= '0;
                r_phase[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (i_load && (i_load_ch == CW'(c))) begin
                    r_step[c] <= i_load_step;
                end
                if (i_load && i_load_clr && (i_load_ch == CW'(c))) begin
                    r_phase[c] <= '0;
                end else if (i_adv && (i_sel == CW'(c))) begin
                    r_phase[c] <= r_phase[c] + r_step[c];
                end
            end
        end
    end

    assign o_phase = r_phase[i_sel];

endmodule

// File: rtl/sine_mux_ctrl.sv
// NCH sine channels share one registered sineROM: one slot per enabled cycle, samples two cycles later.
// Configuration is staged in a single pending register and applied at the frame boundary (slot 0).
module sine_mux_ctrl
    import sine_mux_ctrl_pkg::*;
#(
    parameter  int NCH         = DEF_NCH,
    parameter  int SINEROMSIZE = DEF_SINEROMSIZE,
    parameter  int PHASEW      = DEF_PHASEW,
    localparam int CW          = $clog2(NCH),
    localparam int AW          = $clog2(SINEROMSIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [PHASEW-1:0] cfg_step,
    input  logic              cfg_phase_clr,
    output logic [AW-1:0]     rom_address,
    input  logic [15:0]       rom_svalue,
    output logic              sample_valid,
    output logic [CW-1:0]     sample_ch,
    output logic [15:0]       sample_value,
    output logic              frame_done
);

    logic [CW-1:0]     r_ch_cnt;
    logic [AW-1:0]     r_addr_hold;
    logic              r_pend_vld;
    pend_cfg_t         r_pend;
    logic              r_v1;
    logic [CW-1:0]     r_ch1;
    logic              r_sample_valid;
    logic [CW-1:0]     r_sample_ch;
    logic [15:0]       r_sample_value;
    logic              r_frame_done;

    logic [PHASEW-1:0] w_phase;
    logic [AW-1:0]     w_issue_addr;
    logic              w_apply;
    logic              w_capture;
    logic              w_unused_pend;

    assign w_issue_addr = w_phase[PHASEW-1 -: AW];
    assign w_apply      = r_pend_vld && (r_ch_cnt == '0);
    assign w_capture    = cfg_valid && !r_pend_vld;
    // Upper struct bits beyond this build's widths are carried but never consumed.
    assign w_unused_pend = ^r_pend;

    sine_phase_acc #(
        .NCH    (NCH),
        .PHASEW (PHASEW)
    ) u_phase_acc (
        .clk         (clk),
        .rst         (rst),
        .i_adv       (enable),
        .i_sel       (r_ch_cnt),
        .i_load      (w_apply),
        .i_load_ch   (r_pend.ch[CW-1:0]),
        .i_load_step (r_pend.step[PHASEW-1:0]),
        .i_load_clr  (r_pend.phase_clr),
        .o_phase     (w_phase)
    );

    // slot counter wraps naturally because NCH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch_cnt <= '0;
        end else if (enable) begin
            r_ch_cnt <= r_ch_cnt + CW'(1);
        end
    end

    // last issued address, presented while issuing is paused
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hold <= '0;
        end else if (enable) begin
            r_addr_hold <= w_issue_addr;
        end
    end

    // pending-config capture and release at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
        end else if (w_apply) begin
            r_pend_vld <= 1'b0;
        end else if (w_capture) begin
            r_pend_vld       <= 1'b1;
            r_pend.ch        <= CFG_CH_MAXW'(cfg_ch);
            r_pend.step      <= CFG_STEP_MAXW'(cfg_step);
            r_pend.phase_clr <= cfg_phase_clr;
        end
    end

    // two-stage sample pipeline matching the ROM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1           <= 1'b0;
            r_ch1          <= '0;
            r_sample_valid <= 1'b0;
            r_sample_ch    <= '0;
            r_sample_value <= 16'd0;
            r_frame_done   <= 1'b0;
        end else begin
            r_v1           <= enable;
            r_ch1          <= r_ch_cnt;
            r_sample_valid <= r_v1;
            r_frame_done   <= r_v1 && (r_ch1 == CW'(NCH - 1));
            if (r_v1) begin
                r_sample_ch    <= r_ch1;
                r_sample_value <= rom_svalue;
            end
        end
    end

    // ROM address follows the issuing channel's phase combinationally
    always_comb begin
        rom_address = r_addr_hold;
        if (enable) begin
            rom_address = w_issue_addr;
        end else begin
            rom_address = r_addr_hold;
        end
    end

    assign cfg_ready    = !r_pend_vld;
    assign sample_valid = r_sample_valid;
    assign sample_ch    = r_sample_ch;
    assign sample_value = r_sample_value;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_sine_mux_ctrl.sv
// Randomized bench for sine_mux_ctrl with a cycle-level reference model and a behavioural sineROM.
module tb_sine_mux_ctrl;

    localparam int NCH    = 4;
    localparam int ROMSZ  = 256;
    localparam int PHASEW = 24;
    localparam int CW     = 2;
    localparam int AW     = 8;
    localparam longint PMOD = 64'd1 << PHASEW;
    localparam longint ADIV = 64'd1 << (PHASEW - AW);

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CW-1:0]     cfg_ch;
    logic [PHASEW-1:0] cfg_step;
    logic              cfg_phase_clr;
    logic [AW-1:0]     rom_address;
    logic [15:0]       rom_svalue;
    logic              sample_valid;
    logic [CW-1:0]     sample_ch;
    logic [15:0]       sample_value;
    logic              frame_done;

    always #5 clk = ~clk;

    sine_mux_ctrl #(.NCH(NCH), .SINEROMSIZE(ROMSZ), .PHASEW(PHASEW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_step(cfg_step), .cfg_phase_clr(cfg_phase_clr),
        .rom_address(rom_address), .rom_svalue(rom_svalue),
        .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_value(sample_value), .frame_done(frame_done)
    );

    // ROM image: arbitrary contents with the four reference points pinned
    logic [15:0] rom_img [ROMSZ];
    always @(posedge clk) rom_svalue <= rom_img[rom_address];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    longint m_phase [NCH];
    longint m_step  [NCH];
    int     m_cnt;
    int     m_last_addr;
    bit     m_pend;
    int     m_pch;
    longint m_pstep;
    bit     m_pclr;
    bit     p1v, p2v;
    int     p1ch, p2ch, p1val, p2val;

    bit trk0 = 1'b0;
    int q_a0[$];
    int q_s0[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;
            m_step[c]  = 0;
        end
        m_cnt = 0; m_last_addr = 0; m_pend = 0; m_pch = 0; m_pstep = 0; m_pclr = 0;
        p1v = 0; p2v = 0; p1ch = 0; p2ch = 0; p1val = 0; p2val = 0;
    endtask

    // check this cycle's outputs, advance the model across the edge, then step past it
    task automatic cycle();
        int  exp_addr;
        bit  apply, cap;
        #1;
        exp_addr = enable ? int'(m_phase[m_cnt] / ADIV) : m_last_addr;
        check_eq("rom_address", 32'(rom_address), 32'(exp_addr));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check_eq("sample_valid", 32'(sample_valid), 32'(p2v));
        check_eq("frame_done", 32'(frame_done), 32'(p2v && (p2ch == NCH - 1)));
        if (p2v) begin
            check_eq("sample_ch", 32'(sample_ch), 32'(p2ch));
            check_eq("sample_value", 32'(sample_value), 32'(p2val));
        end
        if (trk0 && enable && (m_cnt == 0)) q_a0.push_back(int'(rom_address));
        if (trk0 && sample_valid && (sample_ch == 0)) q_s0.push_back(int'(sample_value));

        if (rst) begin
            model_reset();
        end else begin
            p2v = p1v; p2ch = p1ch; p2val = p1val;
            p1v = enable; p1ch = m_cnt; p1val = int'(rom_img[exp_addr]);
            apply = m_pend && (m_cnt == 0);
            cap   = cfg_valid && !m_pend;
            if (enable) begin
                m_last_addr    = exp_addr;
                m_phase[m_cnt] = (m_phase[m_cnt] + m_step[m_cnt]) % PMOD;
            end
            if (apply) begin
                m_step[m_pch] = m_pstep;
                if (m_pclr) m_phase[m_pch] = 0;
                m_pend = 0;
            end
            if (cap) begin
                m_pend = 1; m_pch = int'(cfg_ch); m_pstep = longint'(cfg_step); m_pclr = cfg_phase_clr;
            end
            if (enable) m_cnt = (m_cnt + 1) % NCH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_cnt(input int c);
        int k = 0;
        while ((m_cnt != c) && (k < 2 * NCH)) begin
            cycle();
            k++;
        end
        check_eq("run_to_cnt_bound", 32'(m_cnt), 32'(c));
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cfg_ready && (k < 64)) begin
            cycle();
            k++;
        end
        check_eq("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    endtask

    task automatic do_cfg(input int ch, input logic [PHASEW-1:0] step, input bit clr);
        wait_ready();
        cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_step = step; cfg_phase_clr = clr;
        cycle();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int exp_a0 [5];
        int exp_s0 [5];
        exp_a0 = '{0, 64, 128, 192, 0};
        exp_s0 = '{32768, 32768, 65535, 32364, 5};

        for (int a = 0; a < ROMSZ; a++) rom_img[a] = 16'($urandom);
        rom_img[0] = 16'd32768; rom_img[64] = 16'd65535;
        rom_img[128] = 16'd32364; rom_img[192] = 16'd5;

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_step = '0; cfg_phase_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        check_eq("rst_sample_value", 32'(sample_value), 32'd0);
        check_eq("rst_sample_ch", 32'(sample_ch), 32'd0);
        rst = 1'b0;

        // all steps zero: every address 0, every sample the ROM's mid value
        enable = 1'b1;
        run(12);

        // ch0 quarter-wave step
        do_cfg(0, 24'h400000, 1'b0);
        wait_ready();
        trk0 = 1'b1;
        run(22);
        trk0 = 1'b0;
        check_eq("ch0_addr_count", 32'(q_a0.size() >= 5), 32'd1);
        check_eq("ch0_sample_count", 32'(q_s0.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < q_a0.size()) check_eq("ch0_addr_seq", 32'(q_a0[i]), 32'(exp_a0[i]));
            if (i < q_s0.size()) check_eq("ch0_sample_seq", 32'(q_s0[i]), 32'(exp_s0[i]));
        end

        // ch1 configured mid-frame
        run_to_cnt(2);
        do_cfg(1, 24'h010000, 1'b0);
        run(16);

        // ch2 driven to 0x7F0000 then cleared
        do_cfg(2, 24'h7F0000, 1'b1);
        wait_ready();
        run_to_cnt(3);
        do_cfg(2, 24'h000000, 1'b1);
        run_to_cnt(2);
        #1;
        check_eq("ch2_clr_addr", 32'(rom_address), 32'd0);
        run(8);

        // pause mid-frame for three cycles
        run_to_cnt(2);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(12);

        // reset with a config pending
        do_cfg(3, 24'h123456, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        run(12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable        = ($urandom % 5) != 0;
            cfg_valid     = ($urandom % 4) == 0;
            cfg_ch        = CW'($urandom);
            cfg_step      = ($urandom % 2) ? PHASEW'($urandom) : PHASEW'(($urandom % 8) << 16);
            cfg_phase_clr = ($urandom % 3) == 0;
            rst           = ($urandom % 97) == 0;
            cycle();
        end
        rst = 1'b0; cfg_valid = 1'b0; enable = 1'b1;
        run(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
